// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths and saturation helper for the fir_filter output chain
//
// Purpose: default sample widths shared with fir_filter, the output clamp limits
//          and a signed clamp function used by the conditioner.
// Contents: FIR_IN_W, FIR_OUT_W, SAT_MAX, SAT_MIN, sat_clip().
package fir_pkg;

  localparam int FIR_IN_W  = 16;
  localparam int FIR_OUT_W = 8;
  localparam int SAT_MAX   = 2 ** (FIR_OUT_W - 1) - 1;
  localparam int SAT_MIN   = -(2 ** (FIR_OUT_W - 1));

  // Clamp a signed value into [lo, hi]; callers detect clipping by
  // comparing the result against the input.
  function automatic int sat_clip(input int v, input int lo, input int hi);
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO
//
// Purpose: small FWFT FIFO with full/empty/count; rd_data_o always shows the head.
// Ports:
//   clk_i      clock (rising edge)
//   reset_i    synchronous active-high reset, empties the FIFO
//   wr_en_i    push request; ignored when full unless a pop happens the same cycle
//   wr_data_i  data to push
//   rd_en_i    pop request; ignored when empty
//   rd_data_o  head entry (stale when empty)
//   full_o     count == DEPTH
//   empty_o    count == 0
//   count_o    number of stored entries
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a full FIFO may still accept
  // a push when it is popped simultaneously.
  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk_i) begin
    if (do_wr && !reset_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/fir_output_conditioner.sv
// rtl/fir_output_conditioner.sv - round, saturate, decimate and buffer fir_filter output
//
// Purpose: takes the full-precision fir_filter sample stream, keeps 1 of every
//          DECIM valid samples, rounds half-up by SHIFT bits, saturates to OUT_W
//          and presents results from a FWFT FIFO on a valid/ready interface.
// Ports:
//   clk         clock (rising edge)
//   reset       synchronous active-high reset, flushes everything
//   y_in        signed input sample
//   in_valid    y_in valid this cycle
//   out_data    signed conditioned sample (FIFO head, holds last value when empty)
//   out_valid   out_data valid
//   out_ready   consumer accepts
//   overflow    sticky: a kept sample was dropped on a full FIFO
//   clip_count  number of saturated kept samples, holds at 16'hFFFF
module fir_output_conditioner
  import fir_pkg::*;
#(
  parameter int IN_W       = FIR_IN_W,
  parameter int OUT_W      = FIR_OUT_W,
  parameter int SHIFT      = 4,
  parameter int DECIM      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IN_W-1:0]   y_in,
  input  logic              in_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic [15:0]       clip_count
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int LO = -(2 ** (OUT_W - 1));
  localparam int HI = 2 ** (OUT_W - 1) - 1;

  logic [PW-1:0]       phase_q, phase_d;
  logic [OUT_W-1:0]    pipe_q, pipe_d;
  logic                pipe_valid_q, pipe_valid_d;
  logic [15:0]         clip_q, clip_d;
  logic                ovf_q, ovf_d;
  logic [OUT_W-1:0]    last_q, last_d;

  logic signed [IN_W:0] sum, rnd;
  int                   rnd_i, sat_i;
  logic                 keep, clipped, pop;

  logic [OUT_W-1:0]     fifo_rd_data;
  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count;

  // One extra bit of headroom so the rounding offset cannot wrap the
  // largest positive input.
  always_comb begin
    sum     = $signed({y_in[IN_W-1], y_in}) + $signed((IN_W+1)'(2 ** (SHIFT - 1)));
    rnd     = sum >>> SHIFT;
    rnd_i   = int'(rnd);
    sat_i   = sat_clip(rnd_i, LO, HI);
    clipped = (sat_i != rnd_i);
  end

  assign keep      = in_valid && (phase_q == '0);
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = fifo_empty ? last_q : fifo_rd_data;
  assign overflow  = ovf_q;
  assign clip_count = clip_q;

  always_comb begin
    phase_d      = phase_q;
    pipe_d       = pipe_q;
    pipe_valid_d = keep;
    clip_d       = clip_q;
    ovf_d        = ovf_q;
    last_d       = last_q;
    if (in_valid) begin
      phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + 1'b1;
    end
    if (keep) begin
      pipe_d = OUT_W'(sat_i);
      if (clipped && (clip_q != 16'hFFFF)) clip_d = clip_q + 16'd1;
    end
    // The FIFO refuses the push itself; here we only record the loss.
    if (pipe_valid_q && fifo_full && !pop) ovf_d = 1'b1;
    // Remember the head so out_data can hold it once the FIFO drains.
    if (!fifo_empty) last_d = fifo_rd_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q      <= '0;
      pipe_q       <= '0;
      pipe_valid_q <= 1'b0;
      clip_q       <= '0;
      ovf_q        <= 1'b0;
      last_q       <= '0;
    end else begin
      phase_q      <= phase_d;
      pipe_q       <= pipe_d;
      pipe_valid_q <= pipe_valid_d;
      clip_q       <= clip_d;
      ovf_q        <= ovf_d;
      last_q       <= last_d;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .reset_i   (reset),
    .wr_en_i   (pipe_valid_q),
    .wr_data_i (pipe_q),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

endmodule

// File: tb/tb_fir_output_conditioner.sv
// tb/tb_fir_output_conditioner.sv - self-checking bench for fir_output_conditioner
module tb_fir_output_conditioner;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] y_in;
  logic        in_valid;
  logic        out_ready;

  logic [7:0]  d1_data, d2_data;
  logic        d1_valid, d2_valid;
  logic        d1_ovf, d2_ovf;
  logic [15:0] d1_clip, d2_clip;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fir_output_conditioner #(.IN_W(16), .OUT_W(8), .SHIFT(4), .DECIM(1), .FIFO_DEPTH(4)) u_d1 (
    .clk(clk), .reset(reset), .y_in(y_in), .in_valid(in_valid),
    .out_data(d1_data), .out_valid(d1_valid), .out_ready(out_ready),
    .overflow(d1_ovf), .clip_count(d1_clip)
  );

  fir_output_conditioner #(.IN_W(16), .OUT_W(8), .SHIFT(4), .DECIM(2), .FIFO_DEPTH(4)) u_d2 (
    .clk(clk), .reset(reset), .y_in(y_in), .in_valid(in_valid),
    .out_data(d2_data), .out_valid(d2_valid), .out_ready(out_ready),
    .overflow(d2_ovf), .clip_count(d2_clip)
  );

  // Reference model: index 0 is the DECIM=1 instance, index 1 the DECIM=2 one.
  int m_phase [2];
  int m_pv    [2];
  int m_pval  [2];
  int m_mem   [2][4];
  int m_head  [2];
  int m_cnt   [2];
  int m_last  [2];
  int m_ovf   [2];
  int m_clip  [2];

  // Round half up by 16 using floor division, then clamp to 8-bit signed.
  function automatic int cond(input int y, output int clipped);
    int s, r;
    s = y + 8;
    r = (s >= 0) ? s / 16 : -((-s + 15) / 16);
    clipped = 0;
    if (r > 127) begin r = 127; clipped = 1; end
    if (r < -128) begin r = -128; clipped = 1; end
    return r;
  endfunction

  task automatic model_edge(input int k, input int decim);
    int full, pop, c, v;
    if (reset) begin
      m_phase[k] = 0; m_pv[k] = 0; m_pval[k] = 0; m_head[k] = 0;
      m_cnt[k] = 0; m_last[k] = 0; m_ovf[k] = 0; m_clip[k] = 0;
      return;
    end
    full = (m_cnt[k] == 4);
    pop  = (m_cnt[k] > 0) && out_ready;
    if (m_cnt[k] > 0) m_last[k] = m_mem[k][m_head[k]];
    if (pop) begin
      m_head[k] = (m_head[k] + 1) % 4;
      m_cnt[k]  = m_cnt[k] - 1;
    end
    if (m_pv[k] != 0) begin
      if (full && !pop) m_ovf[k] = 1;
      else begin
        m_mem[k][(m_head[k] + m_cnt[k]) % 4] = m_pval[k];
        m_cnt[k] = m_cnt[k] + 1;
      end
    end
    m_pv[k] = in_valid && (m_phase[k] == 0);
    if (m_pv[k] != 0) begin
      v = cond(int'($signed(y_in)), c);
      m_pval[k] = v;
      if (c != 0 && m_clip[k] < 65535) m_clip[k] = m_clip[k] + 1;
    end
    if (in_valid) m_phase[k] = (m_phase[k] + 1) % decim;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cmp_inst(input int k, input logic v, input logic [7:0] d, input logic o, input logic [15:0] c);
    int ed;
    ed = (m_cnt[k] > 0) ? m_mem[k][m_head[k]] : m_last[k];
    check($sformatf("d%0d_valid", k + 1), {31'd0, v}, (m_cnt[k] > 0) ? 1 : 0);
    check($sformatf("d%0d_data", k + 1), $signed(d), ed);
    check($sformatf("d%0d_overflow", k + 1), {31'd0, o}, m_ovf[k]);
    check($sformatf("d%0d_clip", k + 1), {16'd0, c}, m_clip[k]);
  endtask

  task automatic step(input logic rst, input logic v, input int y, input logic rd);
    reset = rst; in_valid = v; y_in = 16'(y); out_ready = rd;
    @(posedge clk);
    model_edge(0, 1);
    model_edge(1, 2);
    #1;
    cmp_inst(0, d1_valid, d1_data, d1_ovf, d1_clip);
    cmp_inst(1, d2_valid, d2_data, d2_ovf, d2_clip);
  endtask

  initial begin
    int y;
    reset = 1'b1; in_valid = 1'b0; y_in = '0; out_ready = 1'b0;

    // 1: reset held with toggling input
    step(1, 1, 16'h1234, 1);
    step(1, 1, -300, 0);
    step(1, 1, 5000, 1);
    check("t1_valid", {31'd0, d1_valid}, 0);
    check("t1_data", $signed(d1_data), 0);

    // 2: rounding, two-cycle latency, negative floors
    step(0, 1, 100, 1);
    check("t2_lat1", {31'd0, d1_valid}, 0);
    step(0, 1, -100, 1);
    check("t2_pos", $signed(d1_data), 6);
    step(0, 0, 0, 1);
    check("t2_neg", $signed(d1_data), -6);
    step(0, 0, 0, 1);
    check("t2_gone", {31'd0, d1_valid}, 0);
    step(0, 0, 0, 1);

    // 3: saturation at both ends
    step(1, 0, 0, 1);
    step(0, 1, 32767, 1);
    step(0, 1, -32768, 1);
    check("t3_hi", $signed(d1_data), 127);
    step(0, 0, 0, 1);
    check("t3_lo", $signed(d1_data), -128);
    step(0, 0, 0, 1);
    check("t3_clip", {16'd0, d1_clip}, 2);

    // 4: decimate by two keeps first of each pair
    step(1, 0, 0, 1);
    step(0, 1, 16, 1);
    step(0, 1, 32, 1);
    check("t4_first", $signed(d2_data), 1);
    step(0, 1, 48, 1);
    check("t4_gap", {31'd0, d2_valid}, 0);
    step(0, 1, 64, 1);
    check("t4_second", $signed(d2_data), 3);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // 5: overflow on a stalled consumer, then in-order drain
    step(1, 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      step(0, 1, 16 * i, 0);
      if (i == 5) check("t5_no_ovf_yet", {31'd0, d1_ovf}, 0);
      if (i == 6) check("t5_ovf", {31'd0, d1_ovf}, 1);
    end
    step(0, 0, 0, 0);
    check("t5_head", $signed(d1_data), 1);
    for (int i = 2; i <= 5; i++) begin
      step(0, 0, 0, 1);
      if (i <= 4) check("t5_drain", $signed(d1_data), i);
    end
    check("t5_empty", {31'd0, d1_valid}, 0);
    check("t5_hold", $signed(d1_data), 4);
    check("t5_sticky", {31'd0, d1_ovf}, 1);

    // 6: push and pop while full, then reset mid-drain
    step(1, 0, 0, 0);
    for (int i = 10; i <= 14; i++) step(0, 1, 16 * i, 0);
    step(0, 0, 0, 1);
    check("t6_no_drop", {31'd0, d1_ovf}, 0);
    check("t6_head", $signed(d1_data), 11);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    check("t6_rst_valid", {31'd0, d1_valid}, 0);
    check("t6_rst_data", $signed(d1_data), 0);
    step(0, 0, 0, 1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 0) y = int'($urandom_range(0, 65535)) - 32768;
      else y = int'($urandom_range(0, 4095)) - 2048;
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), y, $urandom_range(0, 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
